moore_seq_gen_1001: RTL and testbench

Serial frame transmitter that drives the input of a non-overlapping Moore "1001" sequence detector. It loads a parallel word on `start` and shifts it out MSB-first, one bit per clock. It also runs an internal reference Moore tracker on the emitted bits. That tracker produces the cycle-aligned expected detector output `exp_z` and a per-frame match count, so one instance serves as both stimulus source and scoreboard for the detector.

---
 rtl/moore_seq_gen_1001_if.sv | 25 ++
 rtl/moore_seq_gen_1001.sv | 86 ++++++++
 tb/tb_moore_seq_gen_1001.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/moore_seq_gen_1001_if.sv
// Frame request and detector-stimulus bundle for moore_seq_gen_1001.
// master drives start/data_in and observes the serial stream; slave is the generator.
interface moore_seq_gen_1001_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             exp_z;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output start, data_in,
    input  x, x_valid, busy, done, exp_z, match_cnt
  );

  modport slave (
    input  start, data_in,
    output x, x_valid, busy, done, exp_z, match_cnt
  );
endinterface

// File: rtl/moore_seq_gen_1001.sv
// MSB-first frame serializer with a reference non-overlapping Moore "1001" tracker on its own output.
// First bit one cycle after the accepting edge, done at WIDTH+1; start is honoured only in IDLE.
module moore_seq_gen_1001 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  moore_seq_gen_1001_if.slave  bus
);
  localparam int BC_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, DONE} ctl_t;
  typedef enum logic [2:0] {S0, S1, S10, S100, S1001} trk_t;

  ctl_t             ctl_q, ctl_d;
  trk_t             trk_q, trk_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cur_bit;

  assign cur_bit = shift_q[WIDTH-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctl_q     <= IDLE;
      trk_q     <= S0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      trk_q     <= trk_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    ctl_d     = ctl_q;
    trk_d     = trk_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    case (ctl_q)
      IDLE: begin
        if (bus.start) begin
          ctl_d     = SEND;
          shift_d   = bus.data_in;
          bit_cnt_d = '0;
          trk_d     = S0;
          cnt_d     = '0;
        end
      end
      SEND: begin
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BC_W'(WIDTH - 1)) begin
          ctl_d = DONE;
        end
        // S1001 restarts from scratch, so the closing 1 never seeds the next match
        case (trk_q)
          S0:      trk_d = cur_bit ? S1    : S0;
          S1:      trk_d = cur_bit ? S1    : S10;
          S10:     trk_d = cur_bit ? S1    : S100;
          S100:    trk_d = cur_bit ? S1001 : S0;
          default: trk_d = cur_bit ? S1    : S0;
        endcase
        if (trk_d == S1001 && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    ctl_d = IDLE;
      default: ctl_d = IDLE;
    endcase
  end

  assign bus.x         = (ctl_q == SEND) & cur_bit;
  assign bus.x_valid   = (ctl_q == SEND);
  assign bus.busy      = (ctl_q != IDLE);
  assign bus.done      = (ctl_q == DONE);
  assign bus.exp_z     = (trk_q == S1001);
  assign bus.match_cnt = cnt_q;
endmodule

// File: tb/tb_moore_seq_gen_1001.sv
// Runs WIDTH=13, 16 and 32/CNT_W=2 generators side by side against a pattern-scan reference model.
module tb_moore_seq_gen_1001;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] din;

  logic [4:0]  act_v   [3];
  logic [31:0] act_cnt [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  int          WV [3] = '{13, 16, 32};
  int          CM [3] = '{31, 31, 3};
  int          m_mode [3];
  int          m_beat [3];
  logic [31:0] m_word [3];
  bit          m_z    [3];
  int          m_cnt  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int W = (g == 0) ? 13 : (g == 1) ? 16 : 32;
    localparam int C = (g == 2) ? 2 : 5;
    moore_seq_gen_1001_if #(.WIDTH(W), .CNT_W(C)) bus ();
    assign bus.start    = start;
    assign bus.data_in  = din[W-1:0];
    assign act_v[g]     = {bus.x, bus.x_valid, bus.busy, bus.done, bus.exp_z};
    assign act_cnt[g]   = 32'(bus.match_cnt);
    moore_seq_gen_1001 #(.WIDTH(W), .CNT_W(C)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Greedy left-to-right search for non-overlapping 1001 windows in the first n emitted bits.
  function automatic void scan(input logic [31:0] w, input int wl, input int n,
                               output int c, output bit z);
    int last = -1;
    logic [3:0] win;
    c = 0;
    for (int j = 3; j < n; j++) begin
      win = {w[wl-1-(j-3)], w[wl-1-(j-2)], w[wl-1-(j-1)], w[wl-1-j]};
      if (j - 3 > last && win == 4'b1001) begin
        c++;
        last = j;
      end
    end
    z = (n > 0) && (last == n - 1);
  endfunction

  task automatic model_step();
    for (int g = 0; g < 3; g++) begin
      int n;
      int c;
      bit z;
      if (!rst) begin
        m_mode[g] = 0; m_beat[g] = 0; m_z[g] = 0; m_cnt[g] = 0;
      end else if (m_mode[g] == 0) begin
        if (start) begin
          m_mode[g] = 1; m_beat[g] = 0; m_word[g] = din;
        end
      end else if (m_mode[g] == 1) begin
        if (m_beat[g] == WV[g] - 1) m_mode[g] = 2;
        else m_beat[g]++;
      end else begin
        m_mode[g] = 0;
      end
      if (m_mode[g] != 0) begin
        n = (m_mode[g] == 1) ? m_beat[g] : WV[g];
        scan(m_word[g], WV[g], n, c, z);
        m_cnt[g] = (c > CM[g]) ? CM[g] : c;
        m_z[g]   = z;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int g = 0; g < 3; g++) begin
      logic [4:0] ev;
      logic       ex;
      ex = (m_mode[g] == 1) ? m_word[g][WV[g]-1-m_beat[g]] : 1'b0;
      ev = {ex, m_mode[g] == 1, m_mode[g] != 0, m_mode[g] == 2, m_z[g]};
      chk($sformatf("w%0d {x,x_valid,busy,done,exp_z}", WV[g]), 32'(act_v[g]), 32'(ev));
      chk($sformatf("w%0d match_cnt", WV[g]), act_cnt[g], m_cnt[g]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) compare_all();
    end
  endtask

  initial begin
    logic [12:0] xs;
    logic [12:0] zs;
    logic [15:0] zs16;
    int r0, r1;
    bit pb, b;

    rst = 1'b0; start = 1'b1; din = 32'hFFFF_FFFF;
    cyc(2);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("w%0d reset flags", WV[g]), 32'(act_v[g]), 32'd0);
      chk($sformatf("w%0d reset cnt", WV[g]), act_cnt[g], 32'd0);
    end
    chk_en = 1'b1;
    rst = 1'b1; start = 1'b0;
    cyc(1);
    chk("w13 idle after reset busy", 32'(act_v[0][2]), 32'd0);

    // 13-bit directed frame: two non-overlapping matches where overlap would give three
    din = 32'h0000_0929; start = 1'b1;
    cyc(1);
    start = 1'b0;
    xs = '0; zs = '0;
    for (int k = 0; k < 13; k++) begin
      xs[12-k] = act_v[0][4];
      zs[12-k] = act_v[0][0];
      din = $urandom;
      cyc(1);
    end
    chk("w13 x sequence", 32'(xs), 32'h0929);
    chk("w13 exp_z per beat", 32'(zs), 32'h0080);
    chk("w13 done cycle flags", 32'(act_v[0]), 32'h07);
    chk("w13 match_cnt", act_cnt[0], 32'd2);
    cyc(1);
    chk("w13 idle holds exp_z", 32'(act_v[0]), 32'h01);
    cyc(22);

    // 0x9999 on the 16-bit unit, saturation on the 32-bit/2-bit-counter unit
    din = 32'h9999_9999; start = 1'b1;
    cyc(1);
    start = 1'b0;
    zs16 = '0;
    for (int k = 0; k < 16; k++) begin
      zs16[15-k] = act_v[1][0];
      din = $urandom;
      cyc(1);
    end
    chk("w16 exp_z per beat", 32'(zs16), 32'h0888);
    chk("w16 done cycle flags", 32'(act_v[1]), 32'h07);
    chk("w16 match_cnt", act_cnt[1], 32'd4);
    cyc(16);
    chk("w32 done", 32'(act_v[2][1]), 32'd1);
    chk("w32 saturated match_cnt", act_cnt[2], 32'd3);
    cyc(3);

    // start held high: back-to-back frames
    start = 1'b1; r0 = -1; r1 = -1; pb = 1'b0;
    for (int i = 0; i < 80; i++) begin
      din = $urandom;
      cyc(1);
      b = act_v[1][2];
      if (b && !pb) begin
        if (r0 < 0) r0 = i;
        else if (r1 < 0) r1 = i;
      end
      pb = b;
    end
    chk("w16 start-to-start spacing", 32'(r1 - r0), 32'd18);
    start = 1'b0;
    cyc(40);

    // reset at beat 6 aborts the frame with no done pulse
    din = 32'h0000_9000; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(6);
    chk("w16 match_cnt at beat 6", act_cnt[1], 32'd1);
    rst = 1'b0;
    cyc(1);
    chk("w16 flags after abort", 32'(act_v[1]), 32'd0);
    chk("w16 match_cnt after abort", act_cnt[1], 32'd0);
    rst = 1'b1;
    cyc(20);
    din = $urandom; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(40);

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      din   = $urandom;
      rst   = ($urandom_range(0, 99) != 0);
      cyc(1);
    end
    rst = 1'b1; start = 1'b0;
    cyc(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
